// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   MIPS pipeline memory stage. Consumes the EX/MEM latch, owns a word-addressed
//   data memory, resolves the branch decision and drives the MEM/WB latch.
//   A slow memory is modelled by a two-state latency FSM. While an access is
//   pending, stall freezes IF/ID/EX and bubbles are written into MEM/WB.
//
// Parameters
//   DEPTH    data memory size in 32-bit words (power of 2)
//   ADDR_W   word-index width
//   MEM_LAT  stall cycles per load/store (0 = single-cycle memory)
//
// Ports
//   clk              in   rising-edge clock
//   rst              in   asynchronous, active-low reset
//   ctlwb_in    [1:0] in  {regwrite, memtoreg} from EX/MEM
//   ctlm_in     [2:0] in  {branch, memread, memwrite}
//   branch_addr_in    in  branch target from execute
//   alu_result_in     in  byte address for load/store, pass-through otherwise
//   rdata2_in         in  store data
//   muxout_in   [4:0] in  destination register
//   zero_in           in  ALU zero flag
//   pcsrc             out branch taken (combinational)
//   branch_addr_out   out branch target (combinational)
//   stall             out access pending; upstream holds its state while high
//   ctlwb_out   [1:0] out MEM/WB control
//   read_data_out     out MEM/WB load data
//   alu_result_out    out MEM/WB ALU result
//   muxout_out  [4:0] out MEM/WB destination register
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int MEM_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ctlwb_in,
    input  logic [2:0]  ctlm_in,
    input  logic [31:0] branch_addr_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rdata2_in,
    input  logic [4:0]  muxout_in,
    input  logic        zero_in,
    output logic        pcsrc,
    output logic [31:0] branch_addr_out,
    output logic        stall,
    output logic [1:0]  ctlwb_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  muxout_out
);

    // The counter only has to hold MEM_LAT-1; keep at least one bit so the
    // single-cycle configuration still elaborates.
    localparam int             CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam bit             LAT_EN   = (MEM_LAT > 0);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LAT > 0) ? (MEM_LAT - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              stall_int;
    logic              complete;
    logic              mem_op;
    logic [ADDR_W-1:0] idx;
    logic [31:0]       rd_word;
    logic              mem_we;

    logic [31:0]       mem [DEPTH];

    // Branch resolution is purely combinational and independent of the FSM.
    assign pcsrc           = ctlm_in[2] & zero_in;
    assign branch_addr_out = branch_addr_in;

    assign mem_op = ctlm_in[1] | ctlm_in[0];

    // Byte offset bits are dropped; anything above the index wraps mod DEPTH.
    assign idx     = alu_result_in[ADDR_W+1:2];
    assign rd_word = mem[idx];

    // -------------------------------------------------------------------------
    // Latency FSM: next-state, counter and stall/complete decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_int = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && LAT_EN) begin
                    stall_int = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = BUSY;
                end else begin
                    complete  = 1'b1;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    stall_int = 1'b1;
                    cnt_nxt   = cnt - CNT_ONE;
                end else begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Reset forces stall low at once, even while a memory op sits on the inputs.
    assign stall = stall_int & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Data memory: written once per store, on its completion edge only
    // -------------------------------------------------------------------------
    // Gating with rst drops a store whose completion would coincide with reset.
    assign mem_we = rst & complete & ctlm_in[0];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= rdata2_in;
        end
    end

    // -------------------------------------------------------------------------
    // MEM/WB latch
    // -------------------------------------------------------------------------
    // read_data_out captures the pre-write word, so a combined read/write
    // instruction returns the old contents. While stalled only the control
    // field is cleared; the data fields keep their last values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctlwb_out      <= 2'b00;
            read_data_out  <= 32'h0;
            alu_result_out <= 32'h0;
            muxout_out     <= 5'd0;
        end else if (complete) begin
            ctlwb_out      <= ctlwb_in;
            read_data_out  <= rd_word;
            alu_result_out <= alu_result_in;
            muxout_out     <= muxout_in;
        end else begin
            ctlwb_out      <= 2'b00;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
module tb_mem_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rstn_v;
    logic [1:0]  ctlwb_in;
    logic [2:0]  ctlm_in;
    logic [31:0] branch_addr_in;
    logic [31:0] alu_result_in;
    logic [31:0] rdata2_in;
    logic [4:0]  muxout_in;
    logic        zero_in;

    logic [2:0]  pcsrc_v;
    logic [2:0]  stall_v;
    logic [31:0] baddr_v [3];
    logic [1:0]  wb_v    [3];
    logic [31:0] rd_v    [3];
    logic [31:0] alu_v   [3];
    logic [4:0]  mux_v   [3];

    // Three configurations: single-cycle, 2-cycle and 3-cycle memory.
    mem_stage #(.DEPTH(256), .MEM_LAT(0)) u_lat0 (
        .clk(clk), .rst(rstn_v[0]), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in),
        .branch_addr_in(branch_addr_in), .alu_result_in(alu_result_in),
        .rdata2_in(rdata2_in), .muxout_in(muxout_in), .zero_in(zero_in),
        .pcsrc(pcsrc_v[0]), .branch_addr_out(baddr_v[0]), .stall(stall_v[0]),
        .ctlwb_out(wb_v[0]), .read_data_out(rd_v[0]), .alu_result_out(alu_v[0]),
        .muxout_out(mux_v[0]));

    mem_stage #(.DEPTH(256), .MEM_LAT(2)) u_lat2 (
        .clk(clk), .rst(rstn_v[1]), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in),
        .branch_addr_in(branch_addr_in), .alu_result_in(alu_result_in),
        .rdata2_in(rdata2_in), .muxout_in(muxout_in), .zero_in(zero_in),
        .pcsrc(pcsrc_v[1]), .branch_addr_out(baddr_v[1]), .stall(stall_v[1]),
        .ctlwb_out(wb_v[1]), .read_data_out(rd_v[1]), .alu_result_out(alu_v[1]),
        .muxout_out(mux_v[1]));

    mem_stage #(.DEPTH(256), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rstn_v[2]), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in),
        .branch_addr_in(branch_addr_in), .alu_result_in(alu_result_in),
        .rdata2_in(rdata2_in), .muxout_in(muxout_in), .zero_in(zero_in),
        .pcsrc(pcsrc_v[2]), .branch_addr_out(baddr_v[2]), .stall(stall_v[2]),
        .ctlwb_out(wb_v[2]), .read_data_out(rd_v[2]), .alu_result_out(alu_v[2]),
        .muxout_out(mux_v[2]));

    // Transaction-level model: memory contents per instance plus the MEM/WB
    // values every instruction must leave behind.
    int          errors;
    int          checks;
    int          sel;
    int          lat_tab [3] = '{0, 2, 3};
    logic [31:0] mmem [3][256];
    bit          mval [3][256];

    bit          chk_en;
    logic        exp_stall;
    logic [1:0]  exp_ctlwb;
    logic [31:0] exp_rd;
    bit          exp_rdk;
    logic [31:0] exp_alu;
    logic [4:0]  exp_mux;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Cycle-by-cycle comparison of the active instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", {31'b0, stall_v[sel]}, {31'b0, exp_stall});
            check("pcsrc", {31'b0, pcsrc_v[sel]}, {31'b0, ctlm_in[2] & zero_in});
            check("branch_addr_out", baddr_v[sel], branch_addr_in);
            check("ctlwb_out", {30'b0, wb_v[sel]}, {30'b0, exp_ctlwb});
            check("alu_result_out", alu_v[sel], exp_alu);
            check("muxout_out", {27'b0, mux_v[sel]}, {27'b0, exp_mux});
            if (exp_rdk) check("read_data_out", rd_v[sel], exp_rd);
        end
    end

    task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] ba,
                         input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] mx,
                         input logic z);
        ctlwb_in       = wb;
        ctlm_in        = m;
        branch_addr_in = ba;
        alu_result_in  = alu;
        rdata2_in      = d2;
        muxout_in      = mx;
        zero_in        = z;
    endtask

    task automatic model_reset();
        exp_stall = 1'b0;
        exp_ctlwb = 2'b00;
        exp_rd    = 32'h0;
        exp_rdk   = 1'b1;
        exp_alu   = 32'h0;
        exp_mux   = 5'd0;
    endtask

    // Present one instruction and hold it until it completes. Called at
    // posedge+1; returns at posedge+1 just after the completion edge, with the
    // instruction still on the inputs.
    task automatic issue(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] ba,
                         input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] mx,
                         input logic z);
        int   nst;
        int   ix;
        logic [31:0] rdv;
        bit   rdk;
        drive(wb, m, ba, alu, d2, mx, z);
        nst = (m[1] | m[0]) ? lat_tab[sel] : 0;
        for (int k = 0; k < nst; k++) begin
            exp_stall = 1'b1;
            @(posedge clk); #1;
            exp_ctlwb = 2'b00;
        end
        exp_stall = 1'b0;
        ix  = int'((alu >> 2) % 256);
        rdk = mval[sel][ix];
        rdv = mmem[sel][ix];
        if (m[0]) begin
            mmem[sel][ix] = d2;
            mval[sel][ix] = 1'b1;
        end
        @(posedge clk); #1;
        exp_ctlwb = wb;
        exp_alu   = alu;
        exp_mux   = mx;
        exp_rd    = rdv;
        exp_rdk   = rdk;
    endtask

    task automatic nop();
        issue(2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    task automatic switch_to(input int s);
        chk_en = 1'b0;
        drive(2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        rstn_v = 3'b000;
        @(posedge clk); #1;
        sel       = s;
        rstn_v[s] = 1'b1;
        model_reset();
        chk_en = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        sel    = 0;
        chk_en = 1'b0;
        model_reset();
        rstn_v = 3'b000;
        // A store sits on the inputs during reset: stall must still be low.
        drive(2'b00, 3'b001, 32'h0, 32'h10, 32'hFFFF_FFFF, 5'd1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_stall", {31'b0, stall_v[i]}, 32'h0);
            check("reset_ctlwb", {30'b0, wb_v[i]}, 32'h0);
            check("reset_rdata", rd_v[i], 32'h0);
            check("reset_alu", alu_v[i], 32'h0);
            check("reset_mux", {27'b0, mux_v[i]}, 32'h0);
        end

        // ---------------- single-cycle memory ----------------
        switch_to(0);
        issue(2'b00, 3'b001, 32'h0, 32'h10, 32'hDEAD_BEEF, 5'd0, 1'b0);   // sw
        issue(2'b11, 3'b010, 32'h0, 32'h10, 32'h0, 5'd5, 1'b0);           // lw
        check("lat0_lw_data", rd_v[0], 32'hDEAD_BEEF);
        check("lat0_lw_ctlwb", {30'b0, wb_v[0]}, 32'h3);
        // aliasing: 0x403 lands on word 0
        issue(2'b00, 3'b001, 32'h0, 32'h403, 32'h0000_1234, 5'd0, 1'b0);
        issue(2'b11, 3'b010, 32'h0, 32'h000, 32'h0, 5'd6, 1'b0);
        check("alias_data", rd_v[0], 32'h0000_1234);
        // R-type pass-through
        issue(2'b10, 3'b000, 32'h0, 32'h55, 32'hAAAA_AAAA, 5'd7, 1'b0);
        check("rtype_alu", alu_v[0], 32'h55);
        check("rtype_mux", {27'b0, mux_v[0]}, 32'd7);
        issue(2'b11, 3'b010, 32'h0, 32'h10, 32'h0, 5'd8, 1'b0);
        check("rtype_mem_kept", rd_v[0], 32'hDEAD_BEEF);
        // branches
        issue(2'b00, 3'b100, 32'hCAFE_0000, 32'h0, 32'h0, 5'd0, 1'b1);
        check("br_taken", {31'b0, pcsrc_v[0]}, 32'h1);
        check("br_addr", baddr_v[0], 32'hCAFE_0000);
        issue(2'b00, 3'b100, 32'h1234_5678, 32'h0, 32'h0, 5'd0, 1'b0);
        check("br_not_taken", {31'b0, pcsrc_v[0]}, 32'h0);
        // memread & memwrite together: old data read, new data stored
        issue(2'b11, 3'b011, 32'h0, 32'h10, 32'hA5A5_A5A5, 5'd9, 1'b0);
        check("rw_old_data", rd_v[0], 32'hDEAD_BEEF);
        issue(2'b11, 3'b010, 32'h0, 32'h10, 32'h0, 5'd9, 1'b0);
        check("rw_new_data", rd_v[0], 32'hA5A5_A5A5);
        nop();

        // ---------------- two-cycle memory ----------------
        switch_to(1);
        issue(2'b00, 3'b001, 32'h0, 32'h20, 32'h600D_F00D, 5'd0, 1'b0);
        issue(2'b11, 3'b010, 32'h0, 32'h20, 32'h0, 5'd9, 1'b0);
        check("lat2_lw_data", rd_v[1], 32'h600D_F00D);
        check("lat2_lw_mux", {27'b0, mux_v[1]}, 32'd9);
        issue(2'b10, 3'b000, 32'h0, 32'h77, 32'h0, 5'd4, 1'b0);          // no stall
        issue(2'b00, 3'b100, 32'h0000_0040, 32'h0, 32'h0, 5'd0, 1'b1);   // branch, no stall
        issue(2'b00, 3'b001, 32'h0, 32'h20, 32'h0BAD_CAFE, 5'd0, 1'b0);
        issue(2'b11, 3'b010, 32'h0, 32'h20, 32'h0, 5'd2, 1'b0);
        check("lat2_overwrite", rd_v[1], 32'h0BAD_CAFE);
        nop();

        // ---------------- three-cycle memory, reset mid-access ----------------
        switch_to(2);
        issue(2'b00, 3'b001, 32'h0, 32'h30, 32'h1111_1111, 5'd0, 1'b0);
        chk_en = 1'b0;
        drive(2'b00, 3'b001, 32'h0, 32'h30, 32'h2222_2222, 5'd0, 1'b0);
        @(posedge clk); #1;
        check("abort_busy_stall", {31'b0, stall_v[2]}, 32'h1);
        rstn_v[2] = 1'b0;
        #1;
        check("abort_stall", {31'b0, stall_v[2]}, 32'h0);
        check("abort_ctlwb", {30'b0, wb_v[2]}, 32'h0);
        check("abort_alu", alu_v[2], 32'h0);
        check("abort_rdata", rd_v[2], 32'h0);
        check("abort_mux", {27'b0, mux_v[2]}, 32'h0);
        @(posedge clk); #1;
        drive(2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        rstn_v[2] = 1'b1;
        model_reset();
        chk_en = 1'b1;
        issue(2'b11, 3'b010, 32'h0, 32'h30, 32'h0, 5'd3, 1'b0);
        check("abort_no_write", rd_v[2], 32'h1111_1111);
        issue(2'b10, 3'b000, 32'h0, 32'h99, 32'h0, 5'd12, 1'b0);
        nop();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
